// File: rtl/led_panel_pkg.sv
// Shared types and constants for the front-panel LED controller.
package led_panel_pkg;

  typedef enum logic [2:0] {
    LAMP,
    ERROR,
    NOT_READY,
    WARN,
    BUSY,
    READY
  } state_t;

  typedef enum logic [1:0] {
    IDLE,
    FLICK,
    HOLD
  } flick_t;

  localparam logic [3:0] TTS_READY = 4'b1000;
  localparam logic [3:0] TTS_WARN  = 4'b0001;
  localparam logic [3:0] TTS_BUSY  = 4'b0100;
  localparam logic [3:0] TTS_OOS   = 4'b0010;
  localparam logic [3:0] TTS_ERROR = 4'b1100;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running timing tick: one-cycle pulse every TICK_DIV clocks, counter restarts at reset.
module led_tick_gen #(
  parameter int TICK_DIV = 125000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import led_panel_pkg::*;

  localparam int W = cnt_width(TICK_DIV - 1);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_panel_ctrl.sv
// Front-panel red/green LED controller; input -> LED latency is three edges (input, state, output regs).
// Define LED_LAMP_TEST_EN to hold both LEDs on for LAMP_TICKS ticks after reset.
module led_panel_ctrl #(
  parameter int TICK_DIV      = 125000,
  parameter int BLINK_TICKS   = 250,
  parameter int STRETCH_TICKS = 50,
  parameter int LAMP_TICKS    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ttc_ready,
  input  logic [3:0] tts_state,
  input  logic       err_req,
  input  logic       err_clear,
  input  logic       trig_pulse,
  output logic       red_led,
  output logic       green_led
);
  import led_panel_pkg::*;

  localparam int BW      = cnt_width(BLINK_TICKS - 1);
  localparam int SEQ_MAX = ((LAMP_TICKS > STRETCH_TICKS) ? LAMP_TICKS : STRETCH_TICKS) - 1;
  localparam int SW      = cnt_width(SEQ_MAX);

  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);
  localparam logic [BW-1:0] BLINK_ONE    = BW'(1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_TICKS - 1);
  localparam logic [SW-1:0] SEQ_ONE      = SW'(1);
`ifdef LED_LAMP_TEST_EN
  localparam logic [SW-1:0] LAMP_LAST    = SW'(LAMP_TICKS - 1);
  localparam state_t        RST_STATE    = LAMP;
`else
  localparam state_t        RST_STATE    = NOT_READY;
`endif

  logic          tick;
  logic          ttc_q;
  logic [3:0]    tts_q;
  logic          err_req_q;
  logic          err_clr_q;
  logic          trig_q;
  logic          err_latch;
  logic          err_set;
  logic          err_next;
  state_t        state;
  state_t        prio_state;
  state_t        state_next;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  flick_t        flick;
  logic [SW-1:0] seq_cnt;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ttc_q     <= 1'b0;
      tts_q     <= 4'b0000;
      err_req_q <= 1'b0;
      err_clr_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      ttc_q     <= ttc_ready;
      tts_q     <= tts_state;
      err_req_q <= err_req;
      err_clr_q <= err_clear;
      trig_q    <= trig_pulse;
    end
  end

  // State selection looks at the latch's next value so an error shows on the same edge it is latched.
  assign err_set  = err_req_q | (tts_q == TTS_OOS) | (tts_q == TTS_ERROR);
  assign err_next = err_set | (err_latch & ~err_clr_q);

  always_comb begin
    prio_state = BUSY;
    if (err_next) begin
      prio_state = ERROR;
    end else if (!ttc_q) begin
      prio_state = NOT_READY;
    end else begin
      case (tts_q)
        TTS_WARN:  prio_state = WARN;
        TTS_READY: prio_state = READY;
        default:   prio_state = BUSY;
      endcase
    end
  end

  always_comb begin
    state_next = prio_state;
`ifdef LED_LAMP_TEST_EN
    if (state == LAMP && !(tick && seq_cnt == LAMP_LAST)) begin
      state_next = LAMP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      err_latch <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      state     <= state_next;
      err_latch <= err_next;
      if (state_next != state) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_ONE;
        end
      end
    end
  end

  // seq_cnt times the flicker sub-phases in READY and the lamp test in LAMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      flick   <= IDLE;
      seq_cnt <= '0;
    end else if (state_next != state) begin
      flick   <= IDLE;
      seq_cnt <= '0;
    end else begin
      case (flick)
        IDLE: begin
          if (state == READY && trig_q) begin
            flick   <= FLICK;
            seq_cnt <= '0;
          end
        end
        FLICK: begin
          if (tick) begin
            if (seq_cnt == STRETCH_LAST) begin
              flick   <= HOLD;
              seq_cnt <= '0;
            end else begin
              seq_cnt <= seq_cnt + SEQ_ONE;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (seq_cnt == STRETCH_LAST) begin
              flick   <= IDLE;
              seq_cnt <= '0;
            end else begin
              seq_cnt <= seq_cnt + SEQ_ONE;
            end
          end
        end
        default: flick <= IDLE;
      endcase
`ifdef LED_LAMP_TEST_EN
      if (state == LAMP && tick) begin
        seq_cnt <= seq_cnt + SEQ_ONE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_led   <= 1'b1;
      green_led <= 1'b1;
    end else begin
      case (state)
        LAMP: begin
          red_led   <= 1'b0;
          green_led <= 1'b0;
        end
        ERROR: begin
          red_led   <= phase;
          green_led <= 1'b1;
        end
        NOT_READY: begin
          red_led   <= 1'b0;
          green_led <= 1'b1;
        end
        WARN: begin
          red_led   <= ~phase;
          green_led <= phase;
        end
        BUSY: begin
          red_led   <= 1'b1;
          green_led <= phase;
        end
        READY: begin
          red_led   <= 1'b1;
          green_led <= (flick == FLICK);
        end
        default: begin
          red_led   <= 1'b1;
          green_led <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_ctrl.sv
// Directed bench: stimulus queues expected LED changes with cycle windows; a monitor checks every LED change.
module tb_led_panel_ctrl;

  localparam int REL = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ttc_ready = 1'b0;
  logic [3:0] tts_state = 4'b1000;
  logic       err_req = 1'b0;
  logic       err_clear = 1'b0;
  logic       trig_pulse = 1'b0;
  logic       red_led;
  logic       green_led;

  // leds = {red, green}; base = cycle of the stimulus, or REL for "since previous change".
  typedef struct {
    logic [1:0] leds;
    int         base;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         last_chg = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev;

  led_panel_ctrl #(
    .TICK_DIV      (4),
    .BLINK_TICKS   (3),
    .STRETCH_TICKS (2),
    .LAMP_TICKS    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ttc_ready  (ttc_ready),
    .tts_state  (tts_state),
    .err_req    (err_req),
    .err_clear  (err_clear),
    .trig_pulse (trig_pulse),
    .red_led    (red_led),
    .green_led  (green_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [1:0] leds, input int base, input int lo, input int hi, input string name);
    exp_t e;
    e.leds = leds;
    e.base = base;
    e.lo   = lo;
    e.hi   = hi;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: leds {red,green} got %b want %b", name, act, want);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL timeout: %0d expected changes unseen, next %s", sb.size(), sb[0].name);
      sb.delete();
    end
    step(1);
  endtask

  // Monitor: every LED change must match the head of the queue within its window.
  initial begin
    exp_t e;
    int   ref_cyc;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev     = {red_led, green_led};
        last_chg = cyc;
      end else if ({red_led, green_led} !== prev) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_change: leds got %b at cycle %0d, want no change (still %b)",
                   {red_led, green_led}, cyc, prev);
        end else begin
          e = sb.pop_front();
          ref_cyc = (e.base >= 0) ? e.base : last_chg;
          if ({red_led, green_led} === e.leds && (cyc - ref_cyc) >= e.lo && (cyc - ref_cyc) <= e.hi)
            n_pass++;
          else
            $display("FAIL %s: leds got %b after %0d cycles, want %b after %0d..%0d",
                     e.name, {red_led, green_led}, cyc - ref_cyc, e.leds, e.lo, e.hi);
        end
        prev     = {red_led, green_led};
        last_chg = cyc;
      end else if (sb.size() > 0) begin
        e = sb[0];
        ref_cyc = (e.base >= 0) ? e.base : last_chg;
        if (cyc - ref_cyc > e.hi) begin
          void'(sb.pop_front());
          n_chk++;
          $display("FAIL %s: leds still %b after %0d cycles, want %b by %0d",
                   e.name, {red_led, green_led}, cyc - ref_cyc, e.leds, e.hi);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_leds", {red_led, green_led}, 2'b11);
    rst    = 1'b0;
    mon_en = 1'b1;
`ifdef LED_LAMP_TEST_EN
    push(2'b00, cyc, 1, 1, "lamp_on");
    push(2'b01, REL, 17, 20, "lamp_exit_notready");
`else
    push(2'b01, cyc, 1, 1, "reset_exit_notready");
`endif
    @(negedge clk);
    chk("first_cycle_after_rst", {red_led, green_led}, 2'b11);
    wait_done(60);

    ttc_ready = 1'b1;
    tts_state = 4'b1000;
    push(2'b10, cyc, 3, 3, "ready");
    wait_done(20);

    tts_state = 4'b0100;
    push(2'b11, cyc, 12, 15, "busy_first_off");
    push(2'b10, REL, 12, 12, "busy_on");
    push(2'b11, REL, 12, 12, "busy_off");
    wait_done(80);

    tts_state = 4'b1000;
    push(2'b10, cyc, 3, 3, "busy_to_ready");
    wait_done(20);

    err_req = 1'b1;
    push(2'b01, cyc, 3, 3, "err_set");
    push(2'b11, REL, 9, 12, "err_blink_off");
    push(2'b01, REL, 12, 12, "err_blink_on");
    step(1);
    err_req = 1'b0;
    wait_done(60);

    err_clear = 1'b1;
    push(2'b10, cyc, 3, 3, "clear_to_ready");
    step(1);
    err_clear = 1'b0;
    wait_done(20);

    tts_state = 4'b1100;
    push(2'b01, cyc, 3, 3, "tts_error");
    wait_done(20);
    err_clear = 1'b1;
    push(2'b11, REL, 9, 12, "clear_blocked_off");
    step(1);
    err_clear = 1'b0;
    wait_done(40);

    tts_state = 4'b1000;
    err_req   = 1'b1;
    err_clear = 1'b1;
    push(2'b01, REL, 12, 12, "req_and_clear_on");
    push(2'b11, REL, 12, 12, "req_and_clear_off");
    step(1);
    err_req   = 1'b0;
    err_clear = 1'b0;
    wait_done(60);

    err_clear = 1'b1;
    push(2'b10, cyc, 3, 3, "error_cleared");
    step(1);
    err_clear = 1'b0;
    wait_done(20);

    trig_pulse = 1'b1;
    push(2'b11, cyc, 3, 3, "flick_off");
    push(2'b10, REL, 5, 8, "flick_on");
    step(1);
    trig_pulse = 1'b0;
    wait_done(30);
    trig_pulse = 1'b1;
    step(1);
    trig_pulse = 1'b0;
    step(10);
    chk("hold_ignores_trig", {red_led, green_led}, 2'b10);
    trig_pulse = 1'b1;
    push(2'b11, cyc, 3, 3, "reflick_off");
    push(2'b10, REL, 5, 8, "reflick_on");
    step(1);
    trig_pulse = 1'b0;
    wait_done(30);

    tts_state = 4'b0001;
    push(2'b01, cyc, 12, 15, "warn_red_phase");
    push(2'b10, REL, 12, 12, "warn_green_phase");
    wait_done(60);
    ttc_ready = 1'b0;
    push(2'b01, cyc, 3, 3, "drop_ttc_red_solid");
    wait_done(20);
    step(20);
    chk("notready_solid", {red_led, green_led}, 2'b01);

    ttc_ready = 1'b1;
    tts_state = 4'b0100;
    push(2'b10, cyc, 3, 3, "busy_again");
    wait_done(20);
    step(2);
    rst = 1'b1;
    push(2'b11, cyc, 1, 1, "rst_mid_blink");
    step(2);
    chk("rst_hold", {red_led, green_led}, 2'b11);
    rst = 1'b0;
`ifdef LED_LAMP_TEST_EN
    push(2'b00, cyc, 1, 1, "rst_lamp_on");
    push(2'b10, REL, 17, 20, "rst_lamp_exit_busy");
`else
    push(2'b01, cyc, 1, 1, "rst_notready");
    push(2'b10, cyc, 3, 3, "rst_busy");
`endif
    push(2'b11, REL, 9, 12, "rst_busy_off");
    wait_done(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
